// File: rtl/serial_word_packer_pkg.sv
// Shared definitions for the serial word packer and the word buffer.
// Holds the common word width, counter width and FSM encoding.
package serial_word_packer_pkg;

    // Word width shared by the packer and the buffer write port
    localparam int WIDTH_DEF = 16;

    // Width of the completed-word counter
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pk_state_t;

    // Bit counter width for a given word width
    function automatic int bitcnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_word_packer.sv
// Packs a framed MSB-first serial stream into WIDTH-bit words and
// pushes them into the downstream buffer through a one-word hold reg.
//
// Ports:
//   clk_1        write-domain clock (posedge)
//   rst          synchronous active-high reset
//   frame_start  din is the MSB of a new word (with din_valid)
//   din_valid    din carries a valid bit
//   din          serial data bit
//   buf_full     downstream buffer full flag
//   data_out     word presented to the buffer
//   data_out_en  buffer write enable
//   busy         frame partially received
//   overflow     sticky, a completed word was dropped
//   word_cnt     words accepted into the hold register
module serial_word_packer
    import serial_word_packer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             din_valid,
    input  logic             din,
    input  logic             buf_full,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_en,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BW = bitcnt_w(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    pk_state_t        r_state;
    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold_data;
    logic             r_hold_valid;
    logic             r_overflow;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_drain;
    logic             w_done;
    logic [WIDTH-1:0] w_word;

    // Combinational enable so the buffer samples it on the same edge;
    // gated by rst so no write is issued in a reset cycle.
    assign w_drain = r_hold_valid && !buf_full && !rst;

    // A restart (frame_start) in SHIFT takes priority over completion.
    assign w_done = (r_state == SHIFT) && din_valid && !frame_start
                    && (r_bit_cnt == LAST);

    assign w_word = {r_shift[WIDTH-2:0], din};

    assign data_out    = r_hold_data;
    assign data_out_en = w_drain;
    assign busy        = (r_state == SHIFT);
    assign overflow    = r_overflow;
    assign word_cnt    = r_word_cnt;

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (din_valid && frame_start) begin
                        r_shift   <= WIDTH'(din);
                        r_bit_cnt <= BW'(1);
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (din_valid) begin
                        if (frame_start) begin
                            // Abort the partial word, restart silently
                            r_shift   <= WIDTH'(din);
                            r_bit_cnt <= BW'(1);
                        end else if (r_bit_cnt == LAST) begin
                            r_shift   <= w_word;
                            r_bit_cnt <= '0;
                            r_state   <= IDLE;
                        end else begin
                            r_shift   <= w_word;
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Hold register: a slot is free if empty or draining now
            if (w_done) begin
                if (!r_hold_valid || w_drain) begin
                    r_hold_data  <= w_word;
                    r_hold_valid <= 1'b1;
                    r_word_cnt   <= r_word_cnt + CNT_W'(1);
                end else begin
                    // Held word is stuck behind buf_full: drop new one
                    r_overflow <= 1'b1;
                end
            end else if (w_drain) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule
